// File: rtl/pipe_hazard_ctrl_if.sv
// Decode/execute hazard-control bundle: decode-stage operand info in,
// pipeline steering and event counters out.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned selectionBits = 4,
    parameter int unsigned cntWidth      = 16
);
    logic                     dec_valid;
    logic [selectionBits-1:0] dec_rs1;
    logic [selectionBits-1:0] dec_rs2;
    logic                     dec_use_rs1;
    logic                     dec_use_rs2;
    logic [selectionBits-1:0] dec_rd;
    logic                     dec_we;
    logic                     ex_br_taken;

    logic                     stall_f;
    logic                     bubble_de;
    logic                     flush_fd;
    logic [1:0]               state;
    logic [cntWidth-1:0]      stall_cnt;
    logic [cntWidth-1:0]      flush_cnt;

    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2, dec_rd, dec_we,
        output ex_br_taken,
        input  stall_f, bubble_de, flush_fd, state, stall_cnt, flush_cnt
    );

    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2, dec_rd, dec_we,
        input  ex_br_taken,
        output stall_f, bubble_de, flush_fd, state, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: three-slot write scoreboard for RAW stalls (no
// register-file bypass) plus a two-cycle flush sequence after a taken PC write.
module pipe_hazard_ctrl #(
    parameter int unsigned selectionBits = 4,
    parameter int unsigned cntWidth      = 16
) (
    input logic              clk,
    input logic              rst,
    pipe_hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StFlush1  = 2'd1,
        StFlush2  = 2'd2,
        StIllegal = 2'd3
    } state_e;

    localparam logic [cntWidth-1:0] CntOne = cntWidth'(1);

    state_e                   r_state;
    logic [2:0]               r_we;
    logic [selectionBits-1:0] r_rd [3];
    logic [cntWidth-1:0]      r_stall_cnt;
    logic [cntWidth-1:0]      r_flush_cnt;

    logic w_match;
    logic w_hazard;
    logic w_issue;
    logic w_stall;
    logic w_bubble;
    logic w_flush;
    logic w_enter_flush;

    // Every in-flight writer counts until it leaves the write stage.
    always_comb begin
        w_match = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (r_we[k] && ((bus.dec_use_rs1 && (r_rd[k] == bus.dec_rs1)) ||
                            (bus.dec_use_rs2 && (r_rd[k] == bus.dec_rs2)))) begin
                w_match = 1'b1;
            end
        end
        w_hazard = bus.dec_valid & w_match;
    end

    always_comb begin
        w_stall  = 1'b0;
        w_bubble = 1'b0;
        w_flush  = 1'b0;
        if (rst) begin
            case (r_state)
                StRun: begin
                    if (bus.ex_br_taken) begin
                        w_bubble = 1'b1;
                        w_flush  = 1'b1;
                    end else if (w_hazard) begin
                        w_stall  = 1'b1;
                        w_bubble = 1'b1;
                    end
                end
                StFlush1: begin
                    w_bubble = 1'b1;
                    w_flush  = 1'b1;
                end
                StFlush2: begin
                    w_bubble = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign w_issue       = bus.dec_valid & ~w_hazard & (r_state == StRun) & ~bus.ex_br_taken;
    assign w_enter_flush = (r_state == StRun) & bus.ex_br_taken;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StRun;
        end else begin
            case (r_state)
                StRun:    r_state <= bus.ex_br_taken ? StFlush1 : StRun;
                StFlush1: r_state <= StFlush2;
                StFlush2: r_state <= StRun;
                default:  r_state <= StRun;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we <= '0;
            for (int k = 0; k < 3; k++) begin
                r_rd[k] <= '0;
            end
        end else begin
            r_we    <= {r_we[1:0], w_issue & bus.dec_we};
            r_rd[2] <= r_rd[1];
            r_rd[1] <= r_rd[0];
            r_rd[0] <= w_issue ? bus.dec_rd : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CntOne;
            end
            if (w_enter_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CntOne;
            end
        end
    end

    assign bus.stall_f   = w_stall;
    assign bus.bubble_de = w_bubble;
    assign bus.flush_fd  = w_flush;
    assign bus.state     = r_state;
    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scenario bench for pipe_hazard_ctrl: per-cycle expected steering outputs are
// queued as stimulus is driven and compared when the outputs settle.
module tb_pipe_hazard_ctrl;

    localparam int unsigned SB = 4;
    localparam int unsigned CW = 4;

    // {stall_f, bubble_de, flush_fd, state}
    localparam logic [4:0] E_IDLE  = 5'b000_00;
    localparam logic [4:0] E_STALL = 5'b110_00;
    localparam logic [4:0] E_BR    = 5'b011_00;
    localparam logic [4:0] E_F1    = 5'b011_01;
    localparam logic [4:0] E_F2    = 5'b010_10;

    typedef struct packed {
        logic       v;
        logic [3:0] rs1;
        logic       u1;
        logic [3:0] rs2;
        logic       u2;
        logic [3:0] rd;
        logic       we;
        logic       br;
        logic [4:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.selectionBits(SB), .cntWidth(CW)) u_if ();

    pipe_hazard_ctrl #(.selectionBits(SB), .cntWidth(CW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    logic [4:0] sb_q [$];
    int n_checks = 0;
    int n_pass   = 0;

    function automatic vec_t mk(input logic v, input logic [3:0] rs1, input logic u1,
                                input logic [3:0] rs2, input logic u2, input logic [3:0] rd,
                                input logic we, input logic br, input logic [4:0] exp);
        vec_t t;
        t = '{v: v, rs1: rs1, u1: u1, rs2: rs2, u2: u2, rd: rd, we: we, br: br, exp: exp};
        return t;
    endfunction

    function automatic vec_t wr(input logic [3:0] rd);
        return mk(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, rd, 1'b1, 1'b0, E_IDLE);
    endfunction

    function automatic vec_t rd1(input logic [3:0] rs, input logic [4:0] exp);
        return mk(1'b1, rs, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, exp);
    endfunction

    function automatic vec_t rd2(input logic [3:0] rs, input logic [4:0] exp);
        return mk(1'b1, 4'd0, 1'b0, rs, 1'b1, 4'd0, 1'b0, 1'b0, exp);
    endfunction

    function automatic vec_t idle(input logic [4:0] exp);
        return mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, exp);
    endfunction

    function automatic logic [4:0] observed();
        return {u_if.stall_f, u_if.bubble_de, u_if.flush_fd, u_if.state};
    endfunction

    task automatic drive(input vec_t t);
        @(negedge clk);
        u_if.dec_valid   = t.v;
        u_if.dec_rs1     = t.rs1;
        u_if.dec_use_rs1 = t.u1;
        u_if.dec_rs2     = t.rs2;
        u_if.dec_use_rs2 = t.u2;
        u_if.dec_rd      = t.rd;
        u_if.dec_we      = t.we;
        u_if.ex_br_taken = t.br;
        sb_q.push_back(t.exp);
    endtask

    task automatic test_reset();
        u_if.dec_valid   = 1'b1;
        u_if.dec_use_rs1 = 1'b1;
        u_if.ex_br_taken = 1'b1;
        @(negedge clk);
        #2;
        n_checks++;
        if (observed() !== E_IDLE) $display("FAIL reset_out got=%b want=%b", observed(), E_IDLE);
        else n_pass++;
        n_checks++;
        if (u_if.stall_cnt !== 4'd0 || u_if.flush_cnt !== 4'd0)
            $display("FAIL reset_cnt got=%0d/%0d want=0/0", u_if.stall_cnt, u_if.flush_cnt);
        else n_pass++;
        u_if.dec_valid   = 1'b0;
        u_if.dec_use_rs1 = 1'b0;
        u_if.ex_br_taken = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_raw_rs1();
        vec_t tbl [5];
        logic [4:0] e;
        tbl = '{wr(4'd3), rd1(4'd3, E_STALL), rd1(4'd3, E_STALL), rd1(4'd3, E_STALL),
                rd1(4'd3, E_IDLE)};
        foreach (tbl[i]) begin
            drive(tbl[i]);
            #2;
            e = sb_q.pop_front();
            n_checks++;
            if (observed() !== e) $display("FAIL raw_rs1[%0d] got=%b want=%b", i, observed(), e);
            else n_pass++;
        end
        n_checks++;
        if (u_if.stall_cnt !== 4'd3) $display("FAIL raw_rs1_cnt got=%0d want=3", u_if.stall_cnt);
        else n_pass++;
    endtask

    task automatic test_raw_rs2();
        vec_t tbl [5];
        logic [4:0] e;
        tbl = '{wr(4'd5), mk(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 1'b0, E_IDLE),
                rd2(4'd5, E_STALL), rd2(4'd5, E_STALL), rd2(4'd5, E_IDLE)};
        foreach (tbl[i]) begin
            drive(tbl[i]);
            #2;
            e = sb_q.pop_front();
            n_checks++;
            if (observed() !== e) $display("FAIL raw_rs2[%0d] got=%b want=%b", i, observed(), e);
            else n_pass++;
        end
        n_checks++;
        if (u_if.stall_cnt !== 4'd5) $display("FAIL raw_rs2_cnt got=%0d want=5", u_if.stall_cnt);
        else n_pass++;
    endtask

    // Invalid and non-reading decodes must not stall even with a matching writer.
    task automatic test_unused_src();
        vec_t tbl [5];
        logic [4:0] e;
        tbl = '{wr(4'd7), mk(1'b0, 4'd7, 1'b1, 4'd7, 1'b1, 4'd0, 1'b0, 1'b0, E_IDLE),
                mk(1'b1, 4'd7, 1'b0, 4'd7, 1'b0, 4'd0, 1'b0, 1'b0, E_IDLE),
                rd2(4'd7, E_STALL), rd2(4'd7, E_IDLE)};
        foreach (tbl[i]) begin
            drive(tbl[i]);
            #2;
            e = sb_q.pop_front();
            n_checks++;
            if (observed() !== e) $display("FAIL unused[%0d] got=%b want=%b", i, observed(), e);
            else n_pass++;
        end
        n_checks++;
        if (u_if.stall_cnt !== 4'd6) $display("FAIL unused_cnt got=%0d want=6", u_if.stall_cnt);
        else n_pass++;
    endtask

    task automatic test_branch();
        vec_t tbl [5];
        logic [4:0] e;
        tbl = '{wr(4'd9), mk(1'b1, 4'd9, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, E_BR),
                mk(1'b1, 4'd9, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, E_F1),
                mk(1'b1, 4'd9, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, E_F2),
                rd1(4'd9, E_IDLE)};
        foreach (tbl[i]) begin
            drive(tbl[i]);
            #2;
            e = sb_q.pop_front();
            n_checks++;
            if (observed() !== e) $display("FAIL branch[%0d] got=%b want=%b", i, observed(), e);
            else n_pass++;
        end
        n_checks++;
        if (u_if.flush_cnt !== 4'd1 || u_if.stall_cnt !== 4'd6)
            $display("FAIL branch_cnt got=%0d/%0d want=1/6", u_if.flush_cnt, u_if.stall_cnt);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        vec_t tbl [7];
        vec_t b;
        logic [4:0] e;
        b = mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, E_BR);
        tbl[0] = b;
        tbl[1] = b; tbl[1].exp = E_F1;
        tbl[2] = b; tbl[2].exp = E_F2;
        tbl[3] = b;
        tbl[4] = idle(E_F1);
        tbl[5] = idle(E_F2);
        tbl[6] = idle(E_IDLE);
        foreach (tbl[i]) begin
            drive(tbl[i]);
            #2;
            e = sb_q.pop_front();
            n_checks++;
            if (observed() !== e) $display("FAIL b2b[%0d] got=%b want=%b", i, observed(), e);
            else n_pass++;
        end
        n_checks++;
        if (u_if.flush_cnt !== 4'd3) $display("FAIL b2b_cnt got=%0d want=3", u_if.flush_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid_flush();
        vec_t tbl [3];
        logic [4:0] e;
        tbl = '{wr(4'd2), mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, E_BR),
                idle(E_F1)};
        foreach (tbl[i]) begin
            drive(tbl[i]);
            #2;
            e = sb_q.pop_front();
            n_checks++;
            if (observed() !== e) $display("FAIL midrst[%0d] got=%b want=%b", i, observed(), e);
            else n_pass++;
        end
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if (observed() !== E_IDLE || u_if.stall_cnt !== 4'd0 || u_if.flush_cnt !== 4'd0)
            $display("FAIL midrst_async got=%b/%0d/%0d want=%b/0/0", observed(),
                     u_if.stall_cnt, u_if.flush_cnt, E_IDLE);
        else n_pass++;
        @(posedge clk);
        #1 rst = 1'b1;
        drive(rd1(4'd2, E_IDLE));
        #2;
        e = sb_q.pop_front();
        n_checks++;
        if (observed() !== e) $display("FAIL midrst_after got=%b want=%b", observed(), e);
        else n_pass++;
    endtask

    task automatic test_saturate();
        vec_t tbl [5];
        logic [4:0] e;
        int exp_cnt;
        tbl = '{wr(4'd1), rd1(4'd1, E_STALL), rd1(4'd1, E_STALL), rd1(4'd1, E_STALL),
                rd1(4'd1, E_IDLE)};
        for (int k = 0; k < 6; k++) begin
            foreach (tbl[i]) begin
                drive(tbl[i]);
                #2;
                e = sb_q.pop_front();
                n_checks++;
                if (observed() !== e)
                    $display("FAIL sat[%0d][%0d] got=%b want=%b", k, i, observed(), e);
                else n_pass++;
            end
            exp_cnt = (3 * (k + 1) > 15) ? 15 : 3 * (k + 1);
            n_checks++;
            if (u_if.stall_cnt !== 4'(exp_cnt))
                $display("FAIL sat_cnt[%0d] got=%0d want=%0d", k, u_if.stall_cnt, exp_cnt);
            else n_pass++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        u_if.dec_valid   = 1'b0;
        u_if.dec_rs1     = '0;
        u_if.dec_rs2     = '0;
        u_if.dec_use_rs1 = 1'b0;
        u_if.dec_use_rs2 = 1'b0;
        u_if.dec_rd      = '0;
        u_if.dec_we      = 1'b0;
        u_if.ex_br_taken = 1'b0;
        test_reset();
        test_raw_rs1();
        test_raw_rs2();
        test_unused_src();
        test_branch();
        test_back_to_back();
        test_reset_mid_flush();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter selectionBits, default 4, width of register selector fields.
REQ-002 Parameter cntWidth, default 16, width of the performance counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 dec_valid  input  1  decode stage holds a real instruction.
REQ-006 dec_rs1  input  selectionBits  decode source 1 (instruction bits [19:16]).
REQ-007 dec_rs2  input  selectionBits  decode source 2 (instruction bits [15:12]).
REQ-008 dec_use_rs1, dec_use_rs2  input  1 each  the instruction reads that source.
REQ-009 dec_rd  input  selectionBits  decode destination (RegToWrite).
REQ-010 dec_we  input  1  decode writes a register (scalar OR vector enable).
REQ-011 ex_br_taken  input  1  execute stage resolved a PC write (pcWrEn_out).
REQ-012 stall_f  output  1  hold PC and the fetch/decode pipe register.
REQ-013 bubble_de  output  1  zero the control word loaded into the decode/execute pipe.
REQ-014 flush_fd  output  1  load zero into the fetch/decode pipe register.
REQ-015 state  output  2  FSM state encoding (RUN=0, FLUSH1=1, FLUSH2=2).
REQ-016 stall_cnt, flush_cnt  output  cntWidth each  saturating event counters.

Function
REQ-017 Scoreboard SHALL hold three slots {we, rd}: S0=execute, S1=memory, S2=register-file write stage.
REQ-018 Every edge: S2<=S1, S1<=S0, S0<=issued instruction {dec_we, dec_rd} or {0,0} when not issued.
REQ-019 Issued = dec_valid AND NOT hazard AND state==RUN AND NOT ex_br_taken.
REQ-020 Hazard (combinational) = dec_valid AND any slot Sk with we=1 and rd equal to a used source (rs1 with use_rs1, rs2 with use_rs2); the register file has no bypass, so all three slots count.
REQ-021 In RUN with hazard and no ex_br_taken: stall_f=1, bubble_de=1, flush_fd=0; the stall lasts until the producing slot shifts out (at most 3 cycles).
REQ-022 In RUN, ex_br_taken=1: bubble_de=1, flush_fd=1, stall_f=0, next state FLUSH1; flush takes priority over hazard stall.
REQ-023 FLUSH1: bubble_de=1, flush_fd=1, stall_f=0; next state FLUSH2 (squashes the instruction fetched before the PC write lands).
REQ-024 FLUSH2: bubble_de=1, flush_fd=0, stall_f=0; next state RUN.
REQ-025 ex_br_taken while in FLUSH1/FLUSH2 SHALL be ignored (the instruction is already squashed).
REQ-026 Encoding 3 is illegal; it SHALL return to RUN on the next edge with all outputs as in RUN without hazard.
REQ-027 Output latency: stall_f, bubble_de and flush_fd SHALL be combinational from the current inputs and state, with no cycle delay.
REQ-028 stall_cnt SHALL increment once per cycle with stall_f=1; flush_cnt SHALL increment once per entry into FLUSH1; both saturate at all-ones.
REQ-029 When dec_valid=0, no stall; a bubble is issued (S0 <= {0,0}).

Reset
REQ-030 rst=0 SHALL clear all slots, set state RUN, and clear both counters immediately, regardless of clk.
REQ-031 During reset: stall_f=0, bubble_de=0, flush_fd=0.
REQ-032 Reset asserted mid-stall or mid-flush SHALL abort it; the first cycle after release behaves as an empty pipeline.

Verification
REQ-033 Write r3 (dec_we=1, rd=3), then the next instruction reads rs1=3 -> stall_f=1 for exactly 3 cycles, then the instruction issues; stall_cnt=3.
REQ-034 Write r5, one independent instruction, then a read of rs2=5 -> stall_f=1 for exactly 2 cycles.
REQ-035 Instruction reads rs1=7 with use_rs1=0 while S0 holds {1,7} -> no stall.
REQ-036 ex_br_taken=1 in RUN -> flush_fd=1 for 2 cycles, bubble_de=1 for 3 cycles, state RUN->1->2->0, flush_cnt=1; a hazard in the same cycle produces no stall.
REQ-037 Pulse rst low during FLUSH1 with S1={1,2} -> state=0, slots empty; a following read of r2 does not stall.
REQ-038 Force stall_cnt to all-ones via a long stall sequence -> the counter holds its value and does not wrap.
